// File: rtl/mxu_pkg.sv
// Shared types and helpers for the MXU sequencer slice.
package mxu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    LOADW  = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } mxu_state_e;

  // enable_fp_unit encodings driven to the array
  localparam logic [1:0] PREC_INT8 = 2'd0;
  localparam logic [1:0] PREC_FP16 = 2'd1;
  localparam logic [1:0] PREC_BF16 = 2'd2;
  localparam logic [1:0] PREC_FP32 = 2'd3;

  // Cycles (in ce cycles) from an activation beat entering the array to its result
  function automatic int unsigned mxu_fill(input int unsigned rows,
                                           input int unsigned row_dly,
                                           input int unsigned mac_lat);
    return rows * row_dly + mac_lat;
  endfunction

endpackage

// File: rtl/mxu_seq_ctrl_if.sv
// Command, weight, activation and array-control signals of the sequencer.
// master = host/array side, slave = sequencer side.
interface mxu_seq_ctrl_if #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned K_W  = 16
);
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic           start;
  logic [K_W-1:0] k_len;
  logic [1:0]     precision;
  logic           busy;
  logic           done;
  logic           ce_o;
  logic           sclr_o;
  logic [1:0]     enable_fp_unit_o;
  logic           w_valid_i;
  logic           w_load_o;
  logic [RW-1:0]  w_row_o;
  logic           act_valid_i;
  logic           act_ready_o;
  logic           res_valid_o;

  modport master (
    output start, k_len, precision, w_valid_i, act_valid_i,
    input  busy, done, ce_o, sclr_o, enable_fp_unit_o,
           w_load_o, w_row_o, act_ready_o, res_valid_o
  );

  modport slave (
    input  start, k_len, precision, w_valid_i, act_valid_i,
    output busy, done, ce_o, sclr_o, enable_fp_unit_o,
           w_load_o, w_row_o, act_ready_o, res_valid_o
  );

endinterface

// File: rtl/mxu_valid_pipe.sv
// Result-tag shift register; advances only with the array clock enable so
// tags stay aligned with data through stalls.
module mxu_valid_pipe #(
  parameter int unsigned DEPTH = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic tag_i,
  output logic tap_o
);

  logic [DEPTH-1:0] sr_q;

  // Shift a tag in on every enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (en_i) begin
      sr_q <= {sr_q[DEPTH-2:0], tag_i};
    end
  end

  assign tap_o = sr_q[DEPTH-1];

endmodule

// File: rtl/mxu_seq_ctrl.sv
// Job sequencer for a ROWS x COLS MXU systolic array: clear, weight load,
// activation streaming with global stall, drain, done.
// Optional MXU_PERF_CNT_EN adds busy-cycle and stall-cycle counters.
module mxu_seq_ctrl
  import mxu_pkg::*;
#(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned COLS    = 8,
  parameter int unsigned MAC_LAT = 3,
  parameter int unsigned ROW_DLY = 2,
  parameter int unsigned K_W     = 16
) (
  input  logic           clk,
  input  logic           reset,
  mxu_seq_ctrl_if.slave  bus
`ifdef MXU_PERF_CNT_EN
  ,
  output logic [31:0]    perf_cycles,
  output logic [31:0]    perf_stalls
`endif
);

  localparam int unsigned FILL = mxu_fill(ROWS, ROW_DLY, MAC_LAT);
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DW   = $clog2(FILL + COLS);

  mxu_state_e     state_q;
  logic [K_W-1:0] k_len_q;
  logic [K_W-1:0] beat_q;
  logic [1:0]     prec_q;
  logic [RW-1:0]  row_q;
  logic [DW-1:0]  drain_q;

  logic ce_c;
  logic w_load_c;
  logic act_ready_c;
  logic tap;

  // Array enable and handshakes follow the live valid inputs in their states
  always_comb begin
    ce_c        = 1'b0;
    w_load_c    = 1'b0;
    act_ready_c = 1'b0;
    case (state_q)
      CLR:    ce_c = 1'b1;
      LOADW: begin
        w_load_c = bus.w_valid_i;
        ce_c     = bus.w_valid_i;
      end
      STREAM: begin
        act_ready_c = bus.act_valid_i;
        ce_c        = bus.act_valid_i;
      end
      DRAIN:  ce_c = 1'b1;
      default: ;
    endcase
  end

  // Job FSM with its row, beat and drain counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_len_q <= '0;
      beat_q  <= '0;
      prec_q  <= '0;
      row_q   <= '0;
      drain_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            k_len_q <= bus.k_len;
            prec_q  <= bus.precision;
            beat_q  <= '0;
            row_q   <= '0;
            drain_q <= '0;
            state_q <= CLR;
          end
        end
        CLR: begin
          state_q <= (k_len_q == '0) ? DONE : LOADW;
        end
        LOADW: begin
          if (bus.w_valid_i) begin
            if (row_q == RW'(ROWS - 1)) begin
              row_q   <= '0;
              state_q <= STREAM;
            end else begin
              row_q <= row_q + RW'(1);
            end
          end
        end
        STREAM: begin
          if (bus.act_valid_i) begin
            // compare against k_len-1 so the all-ones length never wraps
            if (beat_q == k_len_q - K_W'(1)) begin
              state_q <= DRAIN;
            end
            beat_q <= beat_q + K_W'(1);
          end
        end
        DRAIN: begin
          if (drain_q == DW'(FILL + COLS - 2)) begin
            drain_q <= '0;
            state_q <= DONE;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mxu_valid_pipe #(
    .DEPTH (FILL)
  ) u_valid_pipe (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (ce_c),
    .tag_i (act_ready_c),
    .tap_o (tap)
  );

  assign bus.busy             = (state_q != IDLE);
  assign bus.done             = (state_q == DONE);
  assign bus.sclr_o           = (state_q == CLR);
  assign bus.ce_o             = ce_c;
  assign bus.enable_fp_unit_o = prec_q;
  assign bus.w_load_o         = w_load_c;
  assign bus.w_row_o          = row_q;
  assign bus.act_ready_o      = act_ready_c;
  assign bus.res_valid_o      = tap & ce_c;

`ifdef MXU_PERF_CNT_EN
  // Saturating busy-cycle and stream-stall counters, cleared on accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state_q == IDLE) begin
      if (bus.start) begin
        perf_cycles <= '0;
        perf_stalls <= '0;
      end
    end else begin
      if (perf_cycles != '1) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
      if (state_q == STREAM && !bus.act_valid_i && perf_stalls != '1) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mxu_seq_ctrl.sv
// Scoreboard bench for mxu_seq_ctrl at ROWS=COLS=4, MAC_LAT=3, ROW_DLY=2 (FILL=11).
// Expected events are indexed by ce-cycle count within a job (CLR = 0).
module tb_mxu_seq_ctrl;

  localparam int K_SCLR = 0;
  localparam int K_WLD  = 1;
  localparam int K_ACT  = 2;
  localparam int K_RES  = 3;
  localparam int K_DONE = 4;

  typedef struct {
    int kind;
    int idx;
    int val;
  } ev_t;

  logic clk;
  logic reset;

  mxu_seq_ctrl_if #(.ROWS(4), .K_W(16)) bus ();

`ifdef MXU_PERF_CNT_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_stalls;
`endif

  mxu_seq_ctrl #(
    .ROWS    (4),
    .COLS    (4),
    .MAC_LAT (3),
    .ROW_DLY (2),
    .K_W     (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MXU_PERF_CNT_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_stalls (perf_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_vec  = 0;
  int  n_err  = 0;
  int  job_ce = 0;
  bit  mon_en = 1'b1;
  time t0     = 0;
  ev_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic void push_ev(input int kd, input int ix, input int v);
    ev_t e;
    e.kind = kd;
    e.idx  = ix;
    e.val  = v;
    sbq.push_back(e);
  endfunction

  // Hand-derived job shape: CLR@0, weights@1..4, beats@5.., results 11 ce later, done after 14 drain
  function automatic void push_job(input int k);
    int last;
    last = (k == 0) ? 1 : 19 + k;
    for (int c = 0; c <= last; c++) begin
      if (c == 0) push_ev(K_SCLR, c, 0);
      if (k > 0 && c >= 1 && c <= 4) push_ev(K_WLD, c, c - 1);
      if (k > 0 && c >= 5 && c < 5 + k) push_ev(K_ACT, c, 0);
      if (k > 0 && c >= 16 && c < 16 + k) push_ev(K_RES, c, 0);
      if (c == last) push_ev(K_DONE, c, 0);
    end
  endfunction

  task automatic obs(input int kd, input int v);
    ev_t e;
    n_vec++;
    if (sbq.size() == 0) begin
      n_err++;
      $display("FAIL sb_unexpected: got kind=%0d idx=%0d val=%0d, want no event", kd, job_ce, v);
    end else begin
      e = sbq.pop_front();
      if (e.kind != kd || e.idx != job_ce || e.val != v) begin
        n_err++;
        $display("FAIL sb_event: got kind=%0d idx=%0d val=%0d, want kind=%0d idx=%0d val=%0d",
                 kd, job_ce, v, e.kind, e.idx, e.val);
      end
    end
  endtask

  // Monitor: turn every visible output event into a scoreboard comparison
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.sclr_o) job_ce = 0;
        if (bus.sclr_o) obs(K_SCLR, 0);
        if (bus.w_load_o) obs(K_WLD, int'(bus.w_row_o));
        if (bus.act_ready_o) obs(K_ACT, 0);
        if (bus.res_valid_o) obs(K_RES, 0);
        if (bus.done) obs(K_DONE, 0);
        if (bus.ce_o) job_ce++;
      end
    end
  end

  task automatic pulse_start(input int k, input logic [1:0] prec);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.k_len     = 16'(k);
    bus.precision = prec;
    @(posedge clk);
    t0 = $time;
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int exp_j, input logic [1:0] prec);
    bit seen;
    int j;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      j = int'(($time - t0 - 5) / 10);
      chk("done_latency", 32'(j), 32'(exp_j));
      chk("fp_at_done", 32'(bus.enable_fp_unit_o), 32'(prec));
      chk("busy_at_done", 32'(bus.busy), 32'd1);
      @(negedge clk);
      chk("busy_after_done", 32'(bus.busy), 32'd0);
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("fp_hold", 32'(bus.enable_fp_unit_o), 32'(prec));
    end
  endtask

  task automatic run_job(input int k, input logic [1:0] prec, input int nstall);
    bit seen;
    push_job(k);
    pulse_start(k, prec);
    if (nstall > 0) begin
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (bus.act_ready_o) begin
          seen = 1'b1;
          break;
        end
      end
      chk("first_beat_seen", 32'(seen), 32'd1);
      @(posedge clk);
      #1;
      bus.act_valid_i = 1'b0;
      for (int s = 0; s < nstall; s++) begin
        @(negedge clk);
        chk("stall_ce", 32'(bus.ce_o), 32'd0);
        chk("stall_ready", 32'(bus.act_ready_o), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.act_valid_i = 1'b1;
    end
    wait_done((k == 0) ? 1 : 19 + k + nstall, prec);
  endtask

  initial begin
    bit seen;
    reset           = 1'b0;
    bus.start       = 1'b0;
    bus.k_len       = '0;
    bus.precision   = '0;
    bus.w_valid_i   = 1'b1;
    bus.act_valid_i = 1'b1;

    // reset state
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ce", 32'(bus.ce_o), 32'd0);
    chk("rst_sclr", 32'(bus.sclr_o), 32'd0);
    chk("rst_wload", 32'(bus.w_load_o), 32'd0);
    chk("rst_wrow", 32'(bus.w_row_o), 32'd0);
    chk("rst_ready", 32'(bus.act_ready_o), 32'd0);
    chk("rst_res", 32'(bus.res_valid_o), 32'd0);
    chk("rst_fp", 32'(bus.enable_fp_unit_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // plain job, no stalls
    run_job(5, 2'd1, 0);
    // stalled job: 4 idle cycles after the first beat
    run_job(3, 2'd2, 4);
    // empty job
    run_job(0, 2'd0, 0);

    // start while busy is ignored
    push_job(2);
    pulse_start(2, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.k_len     = 16'd7;
    bus.precision = 2'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(21, 2'd0);
    repeat (4) begin
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 32'd0);
    end
    chk("sb_after_ignore", 32'(sbq.size()), 32'd0);

    // reset in the middle of STREAM
    mon_en = 1'b0;
    pulse_start(5, 2'd3);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.act_ready_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("stream_reached", 32'(seen), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_ce", 32'(bus.ce_o), 32'd0);
    chk("arst_ready", 32'(bus.act_ready_o), 32'd0);
    chk("arst_res", 32'(bus.res_valid_o), 32'd0);
    chk("arst_fp", 32'(bus.enable_fp_unit_o), 32'd0);
    chk("arst_wrow", 32'(bus.w_row_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(bus.busy), 32'd0);
      chk("post_rst_done", 32'(bus.done), 32'd0);
    end
    mon_en = 1'b1;
    run_job(4, 2'd3, 0);

`ifdef MXU_PERF_CNT_EN
    // 27 busy cycles: CLR 1 + LOADW 4 + STREAM 5+2 + DRAIN 14 + DONE 1
    run_job(5, 2'd1, 2);
    chk("perf_cycles", perf_cycles, 32'd27);
    chk("perf_stalls", perf_stalls, 32'd2);
    repeat (3) @(negedge clk);
    chk("perf_cycles_hold", perf_cycles, 32'd27);
    chk("perf_stalls_hold", perf_stalls, 32'd2);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
